// File: rtl/serial_regfile_pkg.sv
// Shared sizing helpers, FSM state type and geometry check for serial_regfile.
package serial_regfile_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  function automatic int calc_phases(input int xlen, input int slice);
    return xlen / slice;
  endfunction

  function automatic int calc_aw(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  function automatic int calc_pw(input int phases);
    return (phases > 1) ? $clog2(phases) : 1;
  endfunction

  // Operand must split into whole slices and take at least two phases.
  function automatic bit geometry_ok(input int xlen, input int slice);
    return (slice > 0) && (xlen % slice == 0) && (xlen / slice >= 2);
  endfunction

endpackage

// File: rtl/serial_regfile_slice_shifter.sv
// PHASES-deep slice shift register: parallel load, LSB-first slice out, slot-indexed slice in.
module slice_shifter
  import serial_regfile_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int SLICE  = 8,
  localparam int PHASES = calc_phases(XLEN, SLICE),
  localparam int PW     = calc_pw(PHASES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [XLEN-1:0]  load_val,
  input  logic             shift,
  input  logic             wr,
  input  logic [PW-1:0]    slot,
  input  logic [SLICE-1:0] din,
  output logic [SLICE-1:0] dout,
  output logic [XLEN-1:0]  merged
);

  logic [PHASES-1:0][SLICE-1:0] sr;
  logic [PHASES-1:0][SLICE-1:0] sr_wr;

  // Contents with this cycle's incoming slice already in place.
  always_comb begin
    sr_wr = sr;
    if (wr) sr_wr[slot] = din;
  end

  always_ff @(posedge clk) begin
    if (rst || clear)  sr <= '0;
    else if (load)     sr <= load_val;
    else if (shift)    sr <= {{SLICE{1'b0}}, sr[PHASES-1:1]};
    else if (wr)       sr <= sr_wr;
  end

  assign dout   = sr[0];
  assign merged = sr_wr;

endmodule

// File: rtl/serial_regfile.sv
// Phase-multiplexed integer register file: XLEN operands moved over SLICE-bit buses, LSB first.
// Optional SERIAL_REGFILE_BYPASS_EN forwards a back-to-back commit into the next snapshot.
module serial_regfile
  import serial_regfile_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int SLICE  = 8,
  parameter  int NREGS  = 16,
  localparam int PHASES = calc_phases(XLEN, SLICE),
  localparam int AW     = calc_aw(NREGS),
  localparam int PW     = calc_pw(PHASES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  input  logic [AW-1:0]    rd,
  input  logic             we,
  input  logic [SLICE-1:0] rd_slice,
  output logic [SLICE-1:0] rs1_slice,
  output logic [SLICE-1:0] rs2_slice,
  output logic [PW-1:0]    phase,
  output logic             busy,
  output logic             done
);

  if (!geometry_ok(XLEN, SLICE)) begin : g_bad_geometry
    $error("serial_regfile: XLEN must be a multiple of SLICE with at least 2 phases");
  end

  state_t          state, state_nx;
  logic            accept, last, commit;
  logic [AW-1:0]   rd_q;
  logic            we_q;
  logic [XLEN-1:0] regs [NREGS];
  logic [XLEN-1:0] rs1_rd, rs2_rd, rs1_snap, rs2_snap, commit_val;
  logic [SLICE-1:0] asm_dout_unused;
  logic [XLEN-1:0]  rs1_merged_unused, rs2_merged_unused;

  assign last   = (state == RUN) && (phase == PW'(PHASES - 1));
  assign commit = last && we_q && (rd_q != '0) && (32'(rd_q) < NREGS);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // A start is only honoured when idle or in the final phase (back-to-back).
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept   = 1'b1;
        state_nx = RUN;
      end
      RUN: if (last) begin
        accept   = start;
        state_nx = start ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
      rd_q  <= '0;
      we_q  <= 1'b0;
    end else begin
      if (accept || last)     phase <= '0;
      else if (state == RUN)  phase <= phase + PW'(1);
      if (accept) begin
        rd_q <= rd;
        we_q <= we;
      end
    end
  end

  // x0 and out-of-range addresses read as zero.
  always_comb begin
    rs1_rd = '0;
    rs2_rd = '0;
    if (rs1 != '0 && 32'(rs1) < NREGS) rs1_rd = regs[rs1];
    if (rs2 != '0 && 32'(rs2) < NREGS) rs2_rd = regs[rs2];
  end

`ifdef SERIAL_REGFILE_BYPASS_EN
  always_comb begin
    rs1_snap = (commit && rs1 == rd_q) ? commit_val : rs1_rd;
    rs2_snap = (commit && rs2 == rd_q) ? commit_val : rs2_rd;
  end
`else
  assign rs1_snap = rs1_rd;
  assign rs2_snap = rs2_rd;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[rd_q] <= commit_val;
    end
  end

  // Read shifters clear at the end of a run so the buses idle at zero.
  slice_shifter #(.XLEN(XLEN), .SLICE(SLICE)) u_rs1 (
    .clk(clk), .rst(rst), .clear(last && !start), .load(accept), .load_val(rs1_snap),
    .shift(state == RUN), .wr(1'b0), .slot('0), .din('0),
    .dout(rs1_slice), .merged(rs1_merged_unused)
  );

  slice_shifter #(.XLEN(XLEN), .SLICE(SLICE)) u_rs2 (
    .clk(clk), .rst(rst), .clear(last && !start), .load(accept), .load_val(rs2_snap),
    .shift(state == RUN), .wr(1'b0), .slot('0), .din('0),
    .dout(rs2_slice), .merged(rs2_merged_unused)
  );

  // Write assembly; its merged view carries the live final slice during the commit cycle.
  slice_shifter #(.XLEN(XLEN), .SLICE(SLICE)) u_rd (
    .clk(clk), .rst(rst), .clear(1'b0), .load(1'b0), .load_val('0),
    .shift(1'b0), .wr(state == RUN), .slot(phase), .din(rd_slice),
    .dout(asm_dout_unused), .merged(commit_val)
  );

  assign busy = (state == RUN);
  assign done = last;

endmodule

// File: tb/tb_serial_regfile.sv
// Randomised scoreboard bench for serial_regfile (default geometry) plus a 16-bit-slice instance.
module tb_serial_regfile;
  localparam int XLEN = 32, SLICE = 8, NREGS = 16, P = 4, AW = 4, PW = 2;

  typedef struct {
    logic [SLICE-1:0] s1, s2;
    logic [PW-1:0]    ph;
    logic             dn;
  } exp_t;

  typedef struct {
    int rs1, rs2, rd;
    bit we;
    logic [XLEN-1:0] data;
  } txn_t;

  logic clk = 0, rst = 1, start = 0, we = 0;
  logic [AW-1:0] rs1 = 0, rs2 = 0, rd = 0;
  logic [SLICE-1:0] rd_slice = 0, rs1_slice, rs2_slice;
  logic [PW-1:0] phase;
  logic busy, done;

  logic rst_b = 1, start_b = 0, we_b = 0;
  logic [4:0] rs1_b = 0, rs2_b = 0, rd_b = 0;
  logic [15:0] rd_slice_b = 0, rs1_slice_b, rs2_slice_b;
  logic phase_b, busy_b, done_b;

  int checks = 0, failures = 0;
  exp_t sbq[$];
  txn_t seq[$];
  logic [XLEN-1:0] mx [NREGS];

  always #5 clk = ~clk;

  serial_regfile #(.XLEN(XLEN), .SLICE(SLICE), .NREGS(NREGS)) dut (
    .clk(clk), .rst(rst), .start(start), .rs1(rs1), .rs2(rs2), .rd(rd), .we(we),
    .rd_slice(rd_slice), .rs1_slice(rs1_slice), .rs2_slice(rs2_slice),
    .phase(phase), .busy(busy), .done(done)
  );

  serial_regfile #(.XLEN(32), .SLICE(16), .NREGS(32)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .rs1(rs1_b), .rs2(rs2_b), .rd(rd_b), .we(we_b),
    .rd_slice(rd_slice_b), .rs1_slice(rs1_slice_b), .rs2_slice(rs2_slice_b),
    .phase(phase_b), .busy(busy_b), .done(done_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] mread(input int a);
    return (a == 0 || a >= NREGS) ? '0 : mx[a];
  endfunction

  task automatic mcommit(input txn_t t);
    if (t.we && t.rd != 0 && t.rd < NREGS) mx[t.rd] = t.data;
  endtask

  task automatic push_exp(input txn_t t);
    logic [XLEN-1:0] v1, v2;
    exp_t e;
    v1 = mread(t.rs1);
    v2 = mread(t.rs2);
    for (int k = 0; k < P; k++) begin
      e.s1 = v1[k*SLICE +: SLICE];
      e.s2 = v2[k*SLICE +: SLICE];
      e.ph = PW'(k);
      e.dn = (k == P - 1);
      sbq.push_back(e);
    end
  endtask

  task automatic drive_start(input txn_t t);
    start = 1;
    rs1 = AW'(t.rs1);
    rs2 = AW'(t.rs2);
    rd  = AW'(t.rd);
    we  = t.we;
  endtask

  // Issue seq back-to-back; optional ignored starts in phases 1-2 and optional reset at abort_at.
  task automatic run_seq(input int abort_at, input bit poke);
    push_exp(seq[0]);
    drive_start(seq[0]);
    @(posedge clk); #1;
    for (int i = 0; i < seq.size(); i++) begin
      for (int k = 0; k < P; k++) begin
        start = 0;
        rd_slice = seq[i].data[k*SLICE +: SLICE];
        if (poke && (k == 1 || k == 2)) begin
          start = 1;
          rs1 = AW'($urandom_range(0, NREGS - 1));
          rd  = AW'($urandom_range(1, NREGS - 1));
          we  = 1;
        end
        if (k == abort_at) rst = 1;
        if (k == P - 1) begin
          if (i + 1 < seq.size()) begin
`ifdef SERIAL_REGFILE_BYPASS_EN
            mcommit(seq[i]);
            push_exp(seq[i+1]);
`else
            push_exp(seq[i+1]);
            mcommit(seq[i]);
`endif
            drive_start(seq[i+1]);
          end else begin
            mcommit(seq[i]);
          end
        end
        @(posedge clk); #1;
        if (k == abort_at) begin
          rst = 0;
          sbq.delete();
          for (int r = 0; r < NREGS; r++) mx[r] = '0;
          check("abort_busy", {busy, done, phase, rs1_slice, rs2_slice}, 0);
          start = 0;
          return;
        end
      end
    end
    start = 0;
    we = 0;
  endtask

  function automatic txn_t mk(input int a1, input int a2, input int d, input bit w,
                              input logic [XLEN-1:0] v);
    txn_t t;
    t.rs1 = a1; t.rs2 = a2; t.rd = d; t.we = w; t.data = v;
    return t;
  endfunction

  // Monitor: pop one expected slice set for every busy cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (busy) begin
        if (sbq.size() == 0) check("busy_without_txn", busy, 0);
        else begin
          e = sbq.pop_front();
          check("rs1_slice", rs1_slice, e.s1);
          check("rs2_slice", rs2_slice, e.s2);
          check("phase", phase, e.ph);
          check("done", done, e.dn);
        end
      end else begin
        check("idle_outputs", {done, phase, rs1_slice, rs2_slice}, 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    for (int r = 0; r < NREGS; r++) mx[r] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    rst_b = 0;
    check("reset_state", {busy, done, phase, rs1_slice, rs2_slice}, 0);
    check("reset_state_b", {busy_b, done_b, phase_b, rs1_slice_b, rs2_slice_b}, 0);

    seq = '{mk(1, 2, 5, 1, 32'h12345678)};              run_seq(-1, 0);
    seq = '{mk(5, 0, 0, 0, 32'h0)};                     run_seq(-1, 0);
    seq = '{mk(0, 0, 7, 1, 32'hDDCCBBAA)};              run_seq(-1, 0);
    seq = '{mk(7, 5, 0, 0, 32'h0)};                     run_seq(-1, 0);
    seq = '{mk(0, 0, 0, 1, 32'hFFFFFFFF)};              run_seq(-1, 0);
    seq = '{mk(0, 0, 0, 0, 32'h0)};                     run_seq(-1, 0);
    seq = '{mk(0, 0, 3, 1, 32'h11111111)};              run_seq(-1, 0);
    seq = '{mk(0, 0, 3, 1, 32'hCAFEF00D), mk(3, 3, 0, 0, 32'h0)}; run_seq(-1, 0);
    seq = '{mk(3, 7, 0, 0, 32'h0)};                     run_seq(-1, 1);
    seq = '{mk(0, 0, 9, 1, 32'h9999AAAA)};              run_seq(2, 0);
    seq = '{mk(9, 5, 0, 0, 32'h0)};                     run_seq(-1, 0);

    for (int n = 0; n < 40; n++) begin
      int len;
      len = $urandom_range(1, 3);
      seq.delete();
      for (int j = 0; j < len; j++)
        seq.push_back(mk($urandom_range(0, NREGS - 1), $urandom_range(0, NREGS - 1),
                         $urandom_range(0, NREGS - 1), 1'($urandom_range(0, 1)), $urandom));
      run_seq(-1, 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    check("sb_drained", sbq.size(), 0);

    // 16-bit slice geometry: write x31 then read it back over two phases.
    start_b = 1; we_b = 1; rd_b = 31; rs1_b = 0; rs2_b = 0;
    @(posedge clk); #1;
    start_b = 0; rd_slice_b = 16'hFFFF;
    @(posedge clk); #1;
    rd_slice_b = 16'h0001;
    check("b_write_done", {busy_b, done_b, phase_b}, 3'b111);
    @(posedge clk); #1;
    start_b = 1; we_b = 0; rs1_b = 31; rs2_b = 31;
    check("b_idle", busy_b, 0);
    @(posedge clk); #1;
    start_b = 0;
    check("b_ph0", {busy_b, done_b, phase_b, rs1_slice_b, rs2_slice_b}, {3'b100, 16'hFFFF, 16'hFFFF});
    @(posedge clk); #1;
    check("b_ph1", {busy_b, done_b, phase_b, rs1_slice_b, rs2_slice_b}, {3'b111, 16'h0001, 16'h0001});
    @(posedge clk); #1;
    check("b_end", {busy_b, done_b, phase_b, rs1_slice_b}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
